// File: rtl/ifid_queue.sv
// Fetch-to-decode instruction queue: first-word fall-through FIFO of {pc, instr}
// pairs with redirect flush and a PC+8 link value alongside the head entry.
module ifid_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  output logic          in_ready,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc8,
  input  logic          out_ready,
  output logic [AW:0]   count
);

  localparam logic [AW:0] LP_DEPTH = (AW + 1)'(DEPTH);

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_cnt;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [63:0]   w_head;

  assign w_full  = (r_cnt == LP_DEPTH);
  assign w_empty = (r_cnt == '0);
  // in_ready depends on occupancy alone, so a full queue refuses a push even during a pop.
  assign w_push  = in_valid & ~w_full;
  assign w_pop   = out_ready & ~w_empty;
  assign w_head  = r_mem[r_rd_ptr];

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign out_pc    = w_empty ? 32'h0 : w_head[63:32];
  assign out_instr = w_empty ? 32'h0 : w_head[31:0];
  assign out_pc8   = w_empty ? 32'h0 : (w_head[63:32] + 32'd8);
  assign count     = r_cnt;

  // Storage is not reset; entries are only observed once written.
  always_ff @(posedge clk) begin
    if (w_push && !reset && !flush) begin
      r_mem[r_wr_ptr] <= {in_pc, in_instr};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule
